dmx_out: RTL and testbench
==========================

# dmx_out

DMX512 transmitter for the fixture board. It reads channel levels from a synchronous frame memory and serialises them onto the RS485 line as continuous DMX512 frames: break, mark-after-break (MAB), start code, then `DMX_CHANNELS` slots of 8N2 at 250 kbaud. It sits beside `dmx_in` in `chip`: its `dmx_tx` drives the RS485 DI pin and its `tx_enable` drives `RS485_DE`, which turns the board into a DMX source or repeater.

## Interface
- `BIT_CYCLES`, 192: clk cycles per DMX bit (48 MHz / 250 kbaud); legal range 8..1023.
- `BREAK_BITS`, 23: break length in bit times (23 × 4 µs = 92 µs).
- `MAB_BITS`, 3: MAB length in bit times (12 µs).
- `DMX_CHANNELS`, 192: data slots per frame; legal range 1..512.
- `START_CODE`, 8'h00: value sent in slot 0.

Ports:
- `clk`  in  1  system clock, 48 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; while high, frames are sent back-to-back.
- `read_address`  out  9  channel index 0..DMX_CHANNELS-1 for the frame memory.
- `read_strobe`  out  1  one-cycle read request; `read_address` is valid in the same cycle.
- `read_data`  in  8  channel level; sampled exactly 1 clk after `read_strobe`.
- `dmx_tx`  out  1  serial line; 1 = mark/idle.
- `tx_enable`  out  1  RS485 driver enable.
- `frame_start`  out  1  one-cycle pulse at the start of each break.
- `busy`  out  1  high from break entry through the last stop bit.

## Operation
- States:
  - IDLE → BREAK when `enable`=1.
  - BREAK (`dmx_tx`=0, BREAK_BITS bits) → MAB.
  - MAB (`dmx_tx`=1, MAB_BITS bits) → SLOT.
  - SLOT: 11 bits per slot (start 0, 8 data bits LSB first, 2 stop bits 1). After the last slot → BREAK if `enable`=1, otherwise IDLE.
- Slot 0 carries START_CODE. Slot k (1..DMX_CHANNELS) carries the memory byte at address k-1.
- Fetch:
  - Pulse `read_strobe` on cycle 0 of the first stop bit of slot k-1, with `read_address`=k-1.
  - Latch `read_data` into a holding register on the next clk.
  - Load the shift register from the holding register at the start of slot k.
  - No strobe is issued during the last slot.
  - `read_address` holds its last value between strobes.
- Internal counters:
  - Cycle counter: 0..BIT_CYCLES-1.
  - Bit counter: 0..max(BREAK_BITS, 10).
  - Slot counter: 10 bits, 0..DMX_CHANNELS.
- Deasserting `enable` mid-frame completes the current frame, then goes to IDLE. No truncated frames are ever sent.
- `tx_enable` = `busy`. Both rise in the same cycle `dmx_tx` first goes low for the break, and both fall after the final stop-bit cycle.
- Reset (asynchronous, any state): go to IDLE. All outputs take their reset values; the current frame is abandoned.
- Reset values: `dmx_tx`=1, `tx_enable`=0, `busy`=0, `frame_start`=0, `read_strobe`=0, `read_address`=0.

## Timing
- All outputs are registered.
- `enable` is sampled in IDLE. BREAK begins on the 1st clk after `enable` is seen high, and `frame_start` pulses in that first BREAK cycle.
- Break lasts BREAK_BITS × BIT_CYCLES cycles (4416 at defaults).
- MAB lasts MAB_BITS × BIT_CYCLES cycles (576).
- A slot lasts 11 × BIT_CYCLES cycles (2112).
- A frame lasts (BREAK_BITS + MAB_BITS + 11 × (1 + DMX_CHANNELS)) × BIT_CYCLES cycles. At defaults that is 4992 + 193 × 2112 = 412608 cycles.
- Back-to-back frames: the next `frame_start` occurs the cycle after the last stop bit ends, with no extra mark time.
- `read_data` must be stable on the clk edge 1 cycle after `read_strobe`. Values presented at other times are ignored.
- A `read_data` change after the latch cycle does not affect the slot currently being sent.

## Test plan
- Reset/idle:
  - Stimulus: `rst`=0 mid-slot, then release with `enable`=0.
  - Required: `dmx_tx`=1 and `tx_enable`=0 immediately on reset, and no `read_strobe` for 10000 cycles after release.
- Single frame:
  - Stimulus: DMX_CHANNELS=3, memory {0xA5,0x00,0xFF}, `enable` high for one cycle.
  - Required: 4416 low, 576 high, then start code as 9 bit-times low + 2 high.
  - Slot 1 bits are 0,1,0,1,0,0,1,0,1,1,1.
  - Total `busy` time = (26 + 44) × 192 = 13440 cycles, then IDLE.
- Fetch timing:
  - Stimulus: as above.
  - Required: exactly 3 `read_strobe` pulses per frame, with addresses 0, 1, 2, each at the first stop bit of the preceding slot.
  - A bench model that drives garbage on `read_data` except on the sample cycle still produces correct bytes.
- Continuous:
  - Stimulus: `enable` held high.
  - Required: `frame_start` pulses spaced exactly 13440 cycles apart (DMX_CHANNELS=3), and `tx_enable` never drops between frames.
- Enable drop:
  - Stimulus: deassert `enable` during slot 2.
  - Required: the frame completes through slot 3's stop bits, then IDLE with `dmx_tx`=1 and no new `frame_start`.
- Max channels:
  - Stimulus: DMX_CHANNELS=512.
  - Required: addresses run 0..511 without wrap, and the frame is 26 × 192 + 513 × 2112 = 1088448 cycles.

Source files
------------

// File: rtl/dmx_out.sv
// DMX512 transmitter: break, mark-after-break, start code, then DMX_CHANNELS
// 8N2 slots fetched from a synchronous frame memory, repeated while enabled.
module dmx_out #(
  parameter int          BIT_CYCLES   = 192,
  parameter int          BREAK_BITS   = 23,
  parameter int          MAB_BITS     = 3,
  parameter int          DMX_CHANNELS = 192,
  parameter logic [7:0]  START_CODE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [8:0] read_address,
  output logic       read_strobe,
  input  logic [7:0] read_data,
  output logic       dmx_tx,
  output logic       tx_enable,
  output logic       frame_start,
  output logic       busy
);

  localparam int BIT_MAX = (BREAK_BITS > 10) ? BREAK_BITS : 10;
  localparam int CYC_W   = $clog2(BIT_CYCLES);
  localparam int BIT_W   = $clog2(BIT_MAX + 1);

  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BREAK_LAST = BIT_W'(BREAK_BITS - 1);
  localparam logic [BIT_W-1:0] MAB_LAST   = BIT_W'(MAB_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(8);
  localparam logic [BIT_W-1:0] STOP_FIRST = BIT_W'(9);
  localparam logic [BIT_W-1:0] SLOT_LAST  = BIT_W'(10);
  localparam logic [9:0]       SLOT_MAX   = 10'(DMX_CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAB, S_SLOT} state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [9:0]       slot_q, slot_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q;
  logic             fetch_q;
  logic             bit_end;

  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             fs_q, fs_d;
  logic             strobe_q, strobe_d;
  logic [8:0]       addr_q, addr_d;

  assign bit_end = (cyc_q == CYC_LAST);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    cyc_d   = bit_end ? '0 : cyc_q + CYC_W'(1);
    bit_d   = bit_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    fs_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (enable) begin
          state_d = S_BREAK;
          fs_d    = 1'b1;
        end
      end
      S_BREAK: if (bit_end) begin
        if (bit_q == BREAK_LAST) begin
          state_d = S_MAB;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_MAB: if (bit_end) begin
        if (bit_q == MAB_LAST) begin
          state_d = S_SLOT;
          bit_d   = '0;
          slot_d  = '0;
          shift_d = START_CODE;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_SLOT: if (bit_end) begin
        if (bit_q == SLOT_LAST) begin
          bit_d = '0;
          if (slot_q == SLOT_MAX) begin
            // Frames are only ever cut at a slot boundary after the last channel.
            state_d = enable ? S_BREAK : S_IDLE;
            fs_d    = enable;
          end else begin
            slot_d  = slot_q + 10'd1;
            shift_d = hold_q;
          end
        end else begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q != '0 && bit_q <= DATA_LAST) shift_d = {1'b0, shift_q[7:1]};
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    unique case (state_d)
      S_BREAK: tx_d = 1'b0;
      S_SLOT:  tx_d = (bit_d == '0) ? 1'b0 : ((bit_d <= DATA_LAST) ? shift_d[0] : 1'b1);
      default: tx_d = 1'b1;
    endcase
    busy_d   = (state_d != S_IDLE);
    strobe_d = (state_d == S_SLOT) && (bit_d == STOP_FIRST) && (cyc_d == '0) &&
               (slot_d != SLOT_MAX);
    addr_d   = strobe_d ? slot_d[8:0] : addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      slot_q   <= '0;
      // NOTE: data registers are reset too; they are few and it keeps the line deterministic after reset.
      shift_q  <= '0;
      hold_q   <= '0;
      fetch_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      fs_q     <= 1'b0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      slot_q   <= slot_d;
      shift_q  <= shift_d;
      fetch_q  <= strobe_q;
      if (fetch_q) hold_q <= read_data;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      fs_q     <= fs_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
    end
  end

  assign dmx_tx       = tx_q;
  assign busy         = busy_q;
  assign tx_enable    = busy_q;
  assign frame_start  = fs_q;
  assign read_strobe  = strobe_q;
  assign read_address = addr_q;

endmodule

// File: tb/tb_dmx_out.sv
// Self-checking bench for dmx_out: a 3-channel instance at 192 cycles/bit and a
// 512-channel instance at 8 cycles/bit, both checked against a frame-position model.
module tb_dmx_out;

  localparam int BC    = 192;
  localparam int NCH   = 3;
  localparam int BC2   = 8;
  localparam int NCH2  = 512;
  localparam int BRK   = 23;
  localparam int MAB   = 3;
  localparam int LEAD  = BRK + MAB;
  localparam int LEN   = (LEAD + 11 * (NCH + 1)) * BC;
  localparam int LEN2  = (LEAD + 11 * (NCH2 + 1)) * BC2;
  localparam logic [7:0] START = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, read_strobe, dmx_tx, tx_enable, frame_start, busy;
  logic [8:0] read_address;
  logic [7:0] read_data;
  logic       rst2, enable2, read_strobe2, dmx_tx2, tx_enable2, frame_start2, busy2;
  logic [8:0] read_address2;
  logic [7:0] read_data2;

  dmx_out #(.BIT_CYCLES(BC), .DMX_CHANNELS(NCH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .read_address(read_address),
    .read_strobe(read_strobe), .read_data(read_data), .dmx_tx(dmx_tx),
    .tx_enable(tx_enable), .frame_start(frame_start), .busy(busy));

  dmx_out #(.BIT_CYCLES(BC2), .DMX_CHANNELS(NCH2)) dut_big (
    .clk(clk), .rst(rst2), .enable(enable2), .read_address(read_address2),
    .read_strobe(read_strobe2), .read_data(read_data2), .dmx_tx(dmx_tx2),
    .tx_enable(tx_enable2), .frame_start(frame_start2), .busy(busy2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Frame model: t counts cycles from the first break cycle.
  function automatic int slot_of(int t, int bc);
    if (t < LEAD * bc) return -1;
    return (t - LEAD * bc) / (11 * bc);
  endfunction

  function automatic int bit_of(int t, int bc);
    return ((t - LEAD * bc) % (11 * bc)) / bc;
  endfunction

  function automatic logic level_of(int t, int bc, logic [7:0] b);
    int bi;
    if (t < BRK * bc) return 1'b0;
    if (t < LEAD * bc) return 1'b1;
    bi = bit_of(t, bc);
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  function automatic logic strobe_at(int t, int bc, int nch);
    int s;
    s = slot_of(t, bc);
    return (s >= 0) && (s < nch) && (bit_of(t, bc) == 9) && (((t - LEAD * bc) % bc) == 0);
  endfunction

  // Frame memories: correct data only in the cycle after a strobe, garbage otherwise.
  logic [7:0] mem  [NCH];
  logic [7:0] mem2 [NCH2];
  logic       pend = 1'b0, pend2 = 1'b0;
  logic [8:0] lat, lat2;

  always @(posedge clk) begin
    #1;
    read_data  = pend  ? mem[int'(lat)]   : 8'($urandom);
    read_data2 = pend2 ? mem2[int'(lat2)] : 8'($urandom);
    pend  = read_strobe;
    lat   = read_address;
    pend2 = read_strobe2;
    lat2  = read_address2;
  end

  int t_mon = 0;
  bit in_frame = 0, rand_mem = 0;
  int line_err = 0, strobe_err = 0, addr_err = 0, busy_err = 0, idle_err = 0, fs_err = 0;
  int addrs[$];
  int runs[$];
  int run_len = 0;
  logic run_lvl;

  always @(negedge clk) begin : mon_main
    int s;
    logic [7:0] b;
    if (!rst) in_frame = 0;
    else begin
      if (frame_start === 1'b1) begin
        if (in_frame) fs_err++;
        in_frame = 1;
        t_mon = 0;
        runs.delete();
        run_lvl = dmx_tx;
        run_len = 0;
        if (rand_mem) foreach (mem[i]) mem[i] = 8'($urandom);
      end
      if (in_frame) begin
        s = slot_of(t_mon, BC);
        b = (s <= 0) ? START : mem[s-1];
        if (dmx_tx !== level_of(t_mon, BC, b)) line_err++;
        if (busy !== 1'b1 || tx_enable !== 1'b1) busy_err++;
        if (read_strobe !== strobe_at(t_mon, BC, NCH)) strobe_err++;
        if (read_strobe === 1'b1) begin
          addrs.push_back(int'(read_address));
          if (int'(read_address) != s) addr_err++;
        end
        if (dmx_tx === run_lvl) run_len++;
        else begin
          runs.push_back(run_len);
          run_lvl = dmx_tx;
          run_len = 1;
        end
        t_mon++;
        if (t_mon == LEN) in_frame = 0;
      end else if (dmx_tx !== 1'b1 || busy !== 1'b0 || tx_enable !== 1'b0 || read_strobe !== 1'b0)
        idle_err++;
    end
  end

  int t2 = 0, strobes2 = 0, last2 = -1, blen2 = 0;
  bit in_frame2 = 0, done2 = 0;
  int line_err2 = 0, strobe_err2 = 0, addr_err2 = 0, busy_err2 = 0, idle_err2 = 0;

  always @(negedge clk) begin : mon_big
    int s;
    logic [7:0] b;
    if (rst2) begin
      if (busy2 === 1'b1) blen2++;
      if (frame_start2 === 1'b1 && !done2) begin
        in_frame2 = 1;
        t2 = 0;
      end
      if (in_frame2) begin
        s = slot_of(t2, BC2);
        b = (s <= 0) ? START : mem2[s-1];
        if (dmx_tx2 !== level_of(t2, BC2, b)) line_err2++;
        if (tx_enable2 !== 1'b1) busy_err2++;
        if (read_strobe2 !== strobe_at(t2, BC2, NCH2)) strobe_err2++;
        if (read_strobe2 === 1'b1) begin
          strobes2++;
          if (int'(read_address2) != last2 + 1) addr_err2++;
          last2 = int'(read_address2);
        end
        t2++;
        if (t2 == LEN2) begin
          in_frame2 = 0;
          done2 = 1;
        end
      end else if (dmx_tx2 !== 1'b1 || busy2 !== 1'b0 || frame_start2 !== 1'b0)
        idle_err2++;
    end
  end

  task automatic wait_fs(input int bound);
    int n = 0;
    while (frame_start !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_errs();
    line_err = 0; strobe_err = 0; addr_err = 0; busy_err = 0; idle_err = 0; fs_err = 0;
    addrs.delete();
  endtask

  initial begin
    int t, low, cnt;
    logic [10:0] bits;
    logic [63:0] pk;
    rst = 1'b0; rst2 = 1'b0; enable = 1'b0; enable2 = 1'b0;
    mem = '{8'hA5, 8'h00, 8'hFF};
    foreach (mem2[i]) mem2[i] = 8'($urandom);
    repeat (3) tick();
    check("reset_tx", dmx_tx, 1);
    check("reset_txen", tx_enable, 0);
    check("reset_busy", busy, 0);
    check("reset_fs", frame_start, 0);
    check("reset_strobe", read_strobe, 0);
    check("reset_addr", read_address, 0);
    rst = 1'b1; rst2 = 1'b1;
    tick();

    // Start a frame on both instances, then reset the small one mid-slot.
    enable = 1'b1; enable2 = 1'b1;
    tick();
    enable = 1'b0; enable2 = 1'b0;
    wait_fs(4);
    check("fs_first", frame_start, 1);
    repeat (9000) tick();
    check("pre_reset_line", line_err, 0);
    check("pre_reset_addr", read_address, 1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_tx", dmx_tx, 1);
    check("async_reset_txen", tx_enable, 0);
    check("async_reset_addr", read_address, 0);
    tick();
    rst = 1'b1;
    clear_errs();
    cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      cnt += int'(read_strobe);
    end
    check("idle_strobes", cnt, 0);
    check("idle_quiet", idle_err, 0);

    // Single frame from a one-cycle enable pulse.
    clear_errs();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_fs(4);
    check("fs_single", frame_start, 1);
    t = 0;
    for (int j = 0; j < 11; j++) begin
      while (t < LEAD * BC + 11 * BC + j * BC + BC / 2) begin
        tick();
        t++;
      end
      bits[j] = dmx_tx;
    end
    check("slot1_bits", bits, 11'b11101001010);
    while (busy === 1'b1 && t < LEN + 100) begin
      tick();
      t++;
    end
    check("busy_len", t, LEN);
    check("break_len", (runs.size() > 0) ? runs[0] : -1, BRK * BC);
    check("mab_len", (runs.size() > 1) ? runs[1] : -1, MAB * BC);
    check("sc_low", (runs.size() > 2) ? runs[2] : -1, 9 * BC);
    check("sc_high", (runs.size() > 3) ? runs[3] : -1, 2 * BC);
    check("strobe_count", addrs.size(), 3);
    pk = 0;
    foreach (addrs[i]) pk = pk * 16 + 64'(addrs[i]);
    check("strobe_addrs", pk, 64'h012);
    check("strobe_pos", strobe_err, 0);
    check("frame_line", line_err, 0);
    repeat (300) tick();
    check("after_idle", idle_err, 0);

    // Continuous frames with random contents, then drop enable in slot 2.
    clear_errs();
    rand_mem = 1;
    enable = 1'b1;
    wait_fs(4);
    check("fs_cont", frame_start, 1);
    t = 0;
    low = 0;
    do begin
      tick();
      t++;
      low += int'(!tx_enable);
    end while (frame_start !== 1'b1 && t < LEN + 100);
    check("fs_spacing", t, LEN);
    check("txen_gap", low, 0);
    t = 0;
    while (t < LEAD * BC + 2 * 11 * BC + 300) begin
      tick();
      t++;
    end
    enable = 1'b0;
    while (busy === 1'b1 && t < LEN + 100) begin
      tick();
      t++;
    end
    check("drop_len", t, LEN);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      cnt += int'(frame_start);
    end
    check("no_restart", cnt, 0);
    check("drop_idle", idle_err, 0);
    check("cont_line", line_err, 0);
    check("cont_strobe", strobe_err, 0);
    check("cont_addr", addr_err, 0);
    check("cont_busy", busy_err, 0);
    check("cont_fs", fs_err, 0);

    // 512-channel instance ran alongside.
    cnt = 0;
    while (!done2 && cnt < 60000) begin
      tick();
      cnt++;
    end
    check("big_done", done2, 1);
    check("big_strobes", strobes2, NCH2);
    check("big_last_addr", last2, NCH2 - 1);
    check("big_addr_order", addr_err2, 0);
    check("big_len", blen2, LEN2);
    check("big_line", line_err2, 0);
    check("big_strobe_pos", strobe_err2, 0);
    check("big_txen", busy_err2, 0);
    check("big_idle", idle_err2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
